// File: rtl/dma_mem_responder.sv
// -----------------------------------------------------------------------------
// dma_mem_responder
//
// Slave-side responder that sits between the DMA master request port and a
// single-port data SRAM macro. Level-held read/write requests are turned into
// single-cycle SRAM accesses with active-low enables. Each access is
// acknowledged with a one-cycle R_valid / W_done pulse, followed by one guard
// cycle (GAP) in which requests are not sampled. The guard cycle gives the
// master time to advance its registered address before the next acceptance.
//
// Optional build macro: RESP_ADDR_CHECK_EN
//   Defined   : addresses are checked at acceptance against the SRAM window
//               [BASE_ADDR, BASE_ADDR + 4*2^ADDR_W) and for word alignment.
//               A bad address skips the SRAM access, sets the sticky addr_err
//               flag, returns ERR_DATA on reads and drops write data, while
//               the completion pulse keeps its normal timing.
//   Undefined : no checking; the word index is AR/AW_ADDR[ADDR_W+1:2] and
//               addr_err stays 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   R_req, AR_ADDR    read request (level) and byte address
//   R_DATA, R_valid   read data and one-cycle read-complete pulse
//   W_req, AW_ADDR,   write request (level), byte address and data
//   W_DATA
//   W_done            one-cycle write-complete pulse
//   CEB, WEB, A, DI   SRAM chip enable, write enable (active low), word
//                     address and write data
//   DO                SRAM read data (registered inside the SRAM)
//   busy              high whenever the responder is not idle
//   addr_err          sticky address-error flag
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module dma_mem_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              R_req,
    input  logic [31:0]       AR_ADDR,
    output logic [31:0]       R_DATA,
    output logic              R_valid,
    input  logic              W_req,
    input  logic [31:0]       AW_ADDR,
    input  logic [31:0]       W_DATA,
    output logic              W_done,
    output logic              CEB,
    output logic              WEB,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       DI,
    input  logic [31:0]       DO,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_RESP = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                ceb_nxt;
    logic                web_nxt;
    logic [ADDR_W-1:0]   a_nxt;
    logic [31:0]         di_nxt;
    logic [31:0]         r_data_nxt;
    logic                r_valid_nxt;
    logic                w_done_nxt;
    logic                busy_nxt;
    logic                addr_err_nxt;

    // Writes win over a simultaneous read, so the write address is the one
    // examined whenever W_req is high.
    logic [31:0]         req_addr;
    assign req_addr = W_req ? AW_ADDR : AR_ADDR;

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] addr);
        return addr[ADDR_W+1:2];
    endfunction

`ifdef RESP_ADDR_CHECK_EN
    // Remembers whether the access in flight was rejected, so the response
    // state knows to return ERR_DATA instead of the SRAM output.
    logic acc_err;
    logic acc_err_nxt;
    logic req_ok;

    // 33-bit compare so a window touching the top of the 4 GiB map cannot wrap.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] ad;
        lo = {1'b0, BASE_ADDR};
        hi = lo + (33'd4 << ADDR_W);
        ad = {1'b0, addr};
        return (ad >= lo) && (ad < hi) && (addr[1:0] == 2'b00);
    endfunction

    assign req_ok = addr_ok(req_addr);
`else
    // Bits outside the word index and the check-only parameters have no
    // function in this build.
    logic unused_cfg;
    assign unused_cfg = ^{req_addr[31:ADDR_W+2], req_addr[1:0], BASE_ADDR, ERR_DATA};
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            CEB      <= 1'b1;
            WEB      <= 1'b1;
            A        <= '0;
            DI       <= '0;
            R_DATA   <= '0;
            R_valid  <= 1'b0;
            W_done   <= 1'b0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
`ifdef RESP_ADDR_CHECK_EN
            acc_err  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            CEB      <= ceb_nxt;
            WEB      <= web_nxt;
            A        <= a_nxt;
            DI       <= di_nxt;
            R_DATA   <= r_data_nxt;
            R_valid  <= r_valid_nxt;
            W_done   <= w_done_nxt;
            busy     <= busy_nxt;
            addr_err <= addr_err_nxt;
`ifdef RESP_ADDR_CHECK_EN
            acc_err  <= acc_err_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (W_req)      state_nxt = WR_RESP;
                else if (R_req) state_nxt = RD_WAIT;
            end
            RD_WAIT: state_nxt = RD_RESP;
            RD_RESP: state_nxt = GAP;
            WR_RESP: state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs. The enables
    // default high, which keeps every CEB=0 (and WEB=0) strobe one cycle long.
    always_comb begin
        ceb_nxt      = 1'b1;
        web_nxt      = 1'b1;
        a_nxt        = A;
        di_nxt       = DI;
        r_data_nxt   = R_DATA;
        r_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        addr_err_nxt = addr_err;
`ifdef RESP_ADDR_CHECK_EN
        acc_err_nxt  = acc_err;
`endif
        unique case (state)
            IDLE: begin
                if (W_req || R_req) begin
`ifdef RESP_ADDR_CHECK_EN
                    acc_err_nxt = !req_ok;
                    if (req_ok) begin
                        ceb_nxt = 1'b0;
                        web_nxt = !W_req;
                        a_nxt   = word_idx(req_addr);
                        if (W_req) di_nxt = W_DATA;
                    end else begin
                        addr_err_nxt = 1'b1;
                    end
`else
                    ceb_nxt = 1'b0;
                    web_nxt = !W_req;
                    a_nxt   = word_idx(req_addr);
                    if (W_req) di_nxt = W_DATA;
`endif
                end
            end
            RD_RESP: begin
                r_valid_nxt = 1'b1;
`ifdef RESP_ADDR_CHECK_EN
                r_data_nxt  = acc_err ? ERR_DATA : DO;
`else
                r_data_nxt  = DO;
`endif
            end
            WR_RESP: begin
                w_done_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dma_mem_responder
//
// Randomized scoreboard bench for dma_mem_responder. A behavioural SRAM macro
// answers CEB/WEB/A/DI with registered DO. The master side issues level-held
// requests; for each one a reference model (word-indexed associative memory
// plus a simple acceptance/timing rule) pushes the expected completion into a
// queue. An independent monitor on the falling edge pops and compares on each
// R_valid / W_done pulse.
// -----------------------------------------------------------------------------
module tb_dma_mem_responder;

    localparam int          ADDR_W  = 14;
    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [31:0] BASE    = 32'h1001_0000;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
    localparam logic [31:0] HI_MASK = ~(32'(DEPTH * 4) - 32'd1);

    logic              clk;
    logic              rst_n;
    logic              R_req;
    logic [31:0]       AR_ADDR;
    logic [31:0]       R_DATA;
    logic              R_valid;
    logic              W_req;
    logic [31:0]       AW_ADDR;
    logic [31:0]       W_DATA;
    logic              W_done;
    logic              CEB;
    logic              WEB;
    logic [ADDR_W-1:0] A;
    logic [31:0]       DI;
    logic [31:0]       DO;
    logic              busy;
    logic              addr_err;

    dma_mem_responder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .ERR_DATA  (ERR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .R_req    (R_req),
        .AR_ADDR  (AR_ADDR),
        .R_DATA   (R_DATA),
        .R_valid  (R_valid),
        .W_req    (W_req),
        .AW_ADDR  (AW_ADDR),
        .W_DATA   (W_DATA),
        .W_done   (W_done),
        .CEB      (CEB),
        .WEB      (WEB),
        .A        (A),
        .DI       (DI),
        .DO       (DO),
        .busy     (busy),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Initial SRAM contents seen by both the macro and the reference model.
    function automatic logic [31:0] pat(input logic [31:0] idx);
        return 32'hA5A5_0000 ^ (idx * 32'h9E37_79B9);
    endfunction

    // Behavioural SRAM macro: one access per CEB=0 edge, registered read data.
    logic [31:0] sram    [DEPTH];
    bit          written [DEPTH];
    always @(posedge clk) begin
        if (!CEB) begin
            if (!WEB) begin
                sram[A]    <= DI;
                written[A] <= 1'b1;
            end else begin
                DO <= written[A] ? sram[A] : pat(32'(A));
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        logic [31:0] widx;
        int          acc;
        int          done;
        bit          access;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [int];
    bit          err_model = 1'b0;
    int          last_done = -10;

    function automatic bit model_ok(input logic [31:0] addr);
`ifdef RESP_ADDR_CHECK_EN
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH) && (addr % 4 == 0);
`else
        return (addr == addr);
`endif
    endfunction

    // A request first visible at edge 'first' is accepted there, unless the
    // responder is still finishing: it is idle again two edges after a pulse.
    task automatic model_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                             input int first, output int acc);
        exp_t e;
        int   idx;
        bit   ok;
        ok  = model_ok(addr);
        idx = int'((addr / 4) % DEPTH);
        acc = (first > last_done + 2) ? first : last_done + 2;
        e.is_wr  = is_wr;
        e.widx   = 32'(idx);
        e.acc    = acc;
        e.done   = acc + (is_wr ? 1 : 2);
        e.access = ok;
        last_done = e.done;
        if (!ok) begin
            err_model = 1'b1;
            e.data = is_wr ? 32'd0 : ERR;
        end else if (is_wr) begin
            ref_mem[idx] = data;
            e.data = data;
        end else begin
            e.data = ref_mem.exists(idx) ? ref_mem[idx] : pat(32'(idx));
        end
        e.err = err_model;
        sbq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int          ceb_cnt = 0;
    int          cap_cyc = 0;
    logic [31:0] cap_a;
    logic        cap_web;
    logic [31:0] cap_di;
    logic [31:0] last_rdata = 32'd0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ceb_cnt    = 0;
            last_rdata = 32'd0;
        end else begin
            if (!WEB) chk("web_without_ceb", 32'(CEB), 32'd0);
            if (!CEB) begin
                ceb_cnt++;
                cap_cyc = cyc;
                cap_a   = 32'(A);
                cap_web = WEB;
                cap_di  = DI;
            end
            if (R_valid || W_done) begin
                chk("pulse_overlap", 32'(R_valid & W_done), 32'd0);
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse actual=R_valid:%0b/W_done:%0b required=none (cycle %0d)",
                             R_valid, W_done, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind_wdone", 32'(W_done), 32'(e.is_wr));
                    chk("pulse_edge", 32'(cyc), 32'(e.done));
                    chk("sram_access_count", 32'(ceb_cnt), 32'(e.access));
                    if (e.access && ceb_cnt == 1) begin
                        chk("sram_access_edge", 32'(cap_cyc), 32'(e.acc));
                        chk("sram_addr", cap_a, e.widx);
                        chk("sram_web", 32'(cap_web), 32'(!e.is_wr));
                        if (e.is_wr) chk("sram_di", cap_di, e.data);
                    end
                    if (!e.is_wr) chk("rd_data", R_DATA, e.data);
                    chk("addr_err", 32'(addr_err), 32'(e.err));
                    chk("busy_at_pulse", 32'(busy), 32'd1);
                end
                ceb_cnt = 0;
            end
            if (R_valid) last_rdata = R_DATA;
            else         chk("rdata_hold", R_DATA, last_rdata);
        end
    end

    // ---------------- master side ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input bit is_wr, input int acc, input bit drop, input bit scram);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (drop && cyc == acc) begin
                if (is_wr) W_req = 1'b0;
                else       R_req = 1'b0;
            end
            if (scram && cyc >= acc) begin
                AR_ADDR = $urandom;
                AW_ADDR = $urandom;
                W_DATA  = $urandom;
            end
            if (is_wr ? W_done : R_valid) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=no_pulse required=pulse (cycle %0d)", is_wr ? "wr" : "rd", cyc);
        end
    endtask

    task automatic txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit drop, input bit scram, input bit hold);
        int acc;
        if (is_wr) begin
            AW_ADDR = addr;
            W_DATA  = data;
            W_req   = 1'b1;
        end else begin
            AR_ADDR = addr;
            R_req   = 1'b1;
        end
        model_txn(is_wr, addr, data, cyc + 1, acc);
        wait_pulse(is_wr, acc, drop, scram);
        if (!hold) begin
            R_req = 1'b0;
            W_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = BASE + ($urandom_range(0, 31) << 2);
`ifdef RESP_ADDR_CHECK_EN
        case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a[1:0] = 2'($urandom_range(1, 3));
            2:       a = BASE - 32'd4;
            3:       a = BASE + 32'(DEPTH * 4);
            default: a = a;
        endcase
`else
        a = (a ^ ($urandom & HI_MASK)) | ($urandom & 32'd3);
`endif
        return a;
    endfunction

    initial begin
        int acc_w;
        int acc_r;
        logic [31:0] d;

        rst_n   = 1'b0;
        R_req   = 1'b1;
        AR_ADDR = BASE + 32'h20;
        W_req   = 1'b0;
        AW_ADDR = 32'd0;
        W_DATA  = 32'd0;
        repeat (3) tick();

        chk("rst_CEB", 32'(CEB), 32'd1);
        chk("rst_WEB", 32'(WEB), 32'd1);
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_DI", DI, 32'd0);
        chk("rst_R_DATA", R_DATA, 32'd0);
        chk("rst_R_valid", 32'(R_valid), 32'd0);
        chk("rst_W_done", 32'(W_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);

        // Request held through reset is accepted on the first edge after release.
        rst_n = 1'b1;
        txn(1'b0, BASE + 32'h20, 32'd0, 1'b0, 1'b0, 1'b0);

        // Write then read back the same word.
        txn(1'b1, 32'h1001_0010, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
        txn(1'b0, 32'h1001_0010, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("readback_value", R_DATA, 32'hCAFE_0001);

        // Descriptor fetch: R_req held, address stepping after each pulse.
        for (int k = 0; k < 5; k++) begin
            txn(1'b1, BASE + 32'h100 + 32'(4 * k), $urandom, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            txn(1'b0, BASE + 32'h100 + 32'(4 * k), 32'd0, 1'b0, 1'b0, (k < 4));
        end

        // Simultaneous read and write to the same word: write first.
        d       = $urandom;
        AW_ADDR = BASE + 32'h40;
        W_DATA  = d;
        AR_ADDR = BASE + 32'h40;
        W_req   = 1'b1;
        R_req   = 1'b1;
        model_txn(1'b1, BASE + 32'h40, d, cyc + 1, acc_w);
        model_txn(1'b0, BASE + 32'h40, 32'd0, cyc + 1, acc_r);
        wait_pulse(1'b1, acc_w, 1'b0, 1'b0);
        W_req = 1'b0;
        wait_pulse(1'b0, acc_r, 1'b0, 1'b0);
        R_req = 1'b0;

        // Requests dropped right after acceptance still complete.
        txn(1'b0, BASE + 32'h40, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("busy_after_gap_rd", 32'(busy), 32'd0);
        txn(1'b1, BASE + 32'h44, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        tick();
        chk("busy_after_gap_wr", 32'(busy), 32'd0);

`ifdef RESP_ADDR_CHECK_EN
        txn(1'b0, 32'h2000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("err_rdata", R_DATA, ERR);
        chk("err_flag", 32'(addr_err), 32'd1);
        txn(1'b1, 32'h1001_0002, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        txn(1'b0, 32'h1001_0000, 32'd0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            txn(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a read: the access is abandoned, no pulse.
        repeat (2) tick();
        AR_ADDR = BASE + 32'h8;
        R_req   = 1'b1;
        tick();
        rst_n = 1'b0;
        R_req = 1'b0;
        #1;
        chk("midrst_CEB", 32'(CEB), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        rst_n     = 1'b1;
        last_done = -10;
        err_model = 1'b0;
        repeat (6) tick();
        chk("midrst_no_pulse_busy", 32'(busy), 32'd0);
        chk("midrst_addr_err", 32'(addr_err), 32'd0);
        txn(1'b0, BASE + 32'h8, 32'd0, 1'b0, 1'b0, 1'b0);

        repeat (6) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
